plantard_encode: RTL and testbench

PLANTARD_ENCODE -- requirements
Module: plantard_encode

---
 rtl/plantard_encode.sv | 108 ++++++++++
 tb/tb_plantard_encode.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/plantard_encode.sv
// Encodes X into the Plantard domain: Y = -X*2^ITER mod Q by ITER modular doublings; ITER+1 edges legal, 1 edge illegal.
// Backpressure: the result is held in HOLD until out_ready; in_ready is high only in IDLE.
module plantard_encode #(
    parameter int W    = 32,
    parameter int ITER = 2 * W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] X,
    input  logic [W-1:0] Q,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] Y,
    output logic         err
);
    localparam int CW = $clog2(ITER + 1);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef logic [W-1:0] word_t;
    typedef enum logic [1:0] {IDLE, DBL, FIN, HOLD} state_t;

    state_t        state_q, state_d;
    word_t         r_q, r_d;
    word_t         q_q, q_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ill_q, ill_d;
    word_t         y_q, y_d;
    logic          err_q, err_d;
    logic          ov_q, ov_d;
    logic [W:0]    t;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
            y_q     <= '0;
            err_q   <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
            y_q     <= y_d;
            err_q   <= err_d;
            ov_q    <= ov_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        ill_d   = ill_q;
        y_d     = y_q;
        err_d   = err_q;
        ov_d    = ov_q;
        t       = {r_q, 1'b0};
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    r_d     = X;
                    q_d     = Q;
                    cnt_d   = '0;
                    ill_d   = ~Q[0] | (Q < word_t'(3)) | (X >= Q);
                    state_d = ill_d ? FIN : DBL;
                end
            end
            DBL: begin
                // r < q on entry, so 2r < 2q and one conditional subtract keeps r < q.
                r_d   = (t >= {1'b0, q_q}) ? word_t'(t - {1'b0, q_q}) : t[W-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                if (ill_q) begin
                    y_d   = '0;
                    err_d = 1'b1;
                end else begin
                    y_d   = (r_q == '0) ? '0 : q_q - r_q;
                    err_d = 1'b0;
                end
                ov_d    = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = ov_q;
    assign Y         = y_q;
    assign err       = err_q;
endmodule

// File: tb/tb_plantard_encode.sv
// Randomized bench for plantard_encode against a direct modular-arithmetic reference.
module tb_plantard_encode;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] X;
    logic [31:0] Q;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Y;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    plantard_encode dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .X        (X),
        .Q        (Q),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Y        (Y),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Y = -(X * 2^64) mod Q, with 2^64 mod Q taken as (2^32 mod Q)^2 mod Q.
    function automatic logic [31:0] ref_enc(input logic [31:0] x, input logic [31:0] q);
        longint unsigned p;
        longint unsigned m;
        p = 64'h1_0000_0000 % 64'(q);
        p = (p * p) % 64'(q);
        m = (64'(x) * p) % 64'(q);
        return (m == 0) ? 32'd0 : q - 32'(m);
    endfunction

    task automatic wait_ready();
        int w = 0;
        while (!in_ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        check("ready_before_req", 64'(in_ready), 64'd1);
    endtask

    task automatic do_op(input logic [31:0] x, input logic [31:0] q, input int hold, input bit early);
        logic [31:0] ye;
        logic [31:0] y0;
        logic        e0;
        bit          ill;
        int          lat;
        ill = !q[0] || (q < 32'd3) || (x >= q);
        ye  = ill ? 32'd0 : ref_enc(x, q);
        wait_ready();
        out_ready = early;
        X         = x;
        Q         = q;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        X        = $urandom;
        Q        = $urandom;
        check("busy_after_accept", 64'(in_ready), 64'd0);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 200);
        check("latency", 64'(lat), ill ? 64'd1 : 64'd65);
        check("y", 64'(Y), 64'(ye));
        check("err", 64'(err), 64'(ill));
        if (!ill) check("y_lt_q", 64'(Y < q), 64'd1);
        y0 = Y;
        e0 = err;
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                in_valid = i[0];
                X        = $urandom;
                Q        = $urandom;
                @(posedge clk); #1;
                check("hold_y", 64'(Y), 64'(y0));
                check("hold_err", 64'(err), 64'(e0));
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_busy", 64'(in_ready), 64'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("valid_drop", 64'(out_valid), 64'd0);
        check("ready_back", 64'(in_ready), 64'd1);
    endtask

    initial begin
        int          seen;
        logic [31:0] q;
        logic [31:0] x;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        X         = '0;
        Q         = '0;
        #1;
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_y", 64'(Y), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        do_op(32'd1, 32'd7, 0, 1'b1);
        do_op(32'd3, 32'd7, 0, 1'b0);
        do_op(32'd2, 32'd5, 1, 1'b0);
        do_op(32'd1, 32'd3, 0, 1'b1);
        do_op(32'd0, 32'd7, 0, 1'b0);
        do_op(32'd1, 32'd8, 0, 1'b0);
        do_op(32'd7, 32'd7, 0, 1'b1);
        do_op(32'd0, 32'd1, 2, 1'b0);
        do_op(32'd626802049, 32'd1073692673, 10, 1'b0);
        do_op(32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 1'b1);

        // Reset in the middle of the doubling loop; Y still holds the previous result.
        wait_ready();
        X        = 32'd2;
        Q        = 32'd5;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_ready", 64'(in_ready), 64'd1);
        check("midrst_y", 64'(Y), 64'd0);
        check("midrst_err", 64'(err), 64'd0);
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("no_valid_after_rst", 64'(seen), 64'd0);
        do_op(32'd2, 32'd5, 0, 1'b1);

        for (int i = 0; i < 150; i++) begin
            do_op($urandom % 32'd1073692673, 32'd1073692673, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 100; i++) begin
            q = $urandom | 32'd1;
            if (q < 32'd3) q = 32'd3;
            x = ($urandom_range(0, 19) == 0) ? $urandom : ($urandom % q);
            if ($urandom_range(0, 19) == 0) q = q & ~32'd1;
            do_op(x, q, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
